lfsr9: RTL and testbench
========================

Name: lfsr9

Overview:
- Free-running Fibonacci linear-feedback shift register producing a pseudo-random WIDTH-bit state every clock.
- Default WIDTH=9 gives a maximal-length 511-state sequence.
- Feeds the apple-coordinate generator, which slices and permutes `ps` bits into x/y coordinates.
- Also provides enable, seed load and lock-up flagging for reuse elsewhere.

Parameters:
- WIDTH, 9, register width. Legal range 3..16. Taps come from an internal maximal-length table, one entry per width.
- SEED, 1, reset and recovery state. Must be non-zero in the low WIDTH bits; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset. Forces `ps` to SEED immediately.
- en  input  1  advance enable. Tie high for free-running use; free-running is the default integration.
- load  input  1  synchronous seed load strobe.
- seed_in  input  WIDTH  value captured when `load`=1.
- ps  output  WIDTH  present LFSR state, registered.
- lockup  output  1  combinational flag, high when `ps`==0.

Behaviour:
- One clock; reset is asynchronous and active-high.
- While `reset`=1: `ps`=SEED and `lockup`=0, regardless of `clk`.
- Release of reset is synchronised by the user. The first update happens on the first rising clk edge with `reset`=0.
- Priority at each rising edge: `reset` > `load` > `en`.
  - `load`=1: `ps` <= `seed_in` on that edge, whatever `en` is.
  - `load`=0, `en`=1: `ps` <= {ps[WIDTH-2:0], fb}, where fb is the XOR of the tap bits.
  - `load`=0, `en`=0: `ps` holds its value.
- Shift direction is left: bit 0 receives fb and bit WIDTH-1 is discarded.
- Tap table, XOR, polynomial x^WIDTH + ... + 1:
  - 3: [2,1]
  - 4: [3,2]
  - 5: [4,2]
  - 6: [5,4]
  - 7: [6,5]
  - 8: [7,5,4,3]
  - 9: [8,4]
  - 10: [9,6]
  - 11: [10,8]
  - 12: [11,10,9,3]
  - 13: [12,11,10,7]
  - 14: [13,12,11,1]
  - 15: [14,13]
  - 16: [15,14,12,3]
- WIDTH=9: fb = ps[8] ^ ps[4].
- Latency: one clock from an enabled edge to the new `ps`. There is no combinational path from inputs to `ps`.
- Period from any non-zero state is 2^WIDTH-1; all non-zero states are visited. State 0 is the XOR lock-up state and is never reached by shifting.
- State 0 is reachable only by loading `seed_in`=0. `lockup` then asserts in the same cycle that `ps` becomes 0.
- No X propagation: all state bits are reset.

Optional Feature:
- Macro: LFSR9_LOCKUP_RECOVER_EN.
- Defined:
  - A `load` of all-zero `seed_in` loads SEED instead.
  - Any cycle with `ps`==0 and `en`=1 loads SEED on the next edge.
  - As a result, `lockup` can only pulse for at most one cycle.
- Undefined: zero is loaded verbatim and `ps` stays 0 (with `lockup`=1) until reset or a non-zero load.

Test Plan:
1. Reset release: assert `reset` mid-cycle → `ps`=9'h001 immediately; `lockup`=0.
2. `en`=1 from 9'h001 → successive `ps` = 9'h002, 9'h004, 9'h008, 9'h010, 9'h021; 511 enabled clocks return to 9'h001 with no intermediate repeat and no zero.
3. `en`=0 for 10 cycles at 9'h021 → `ps` stays 9'h021; then `en`=1 → `ps`=9'h042.
4. `load`=1 with `seed_in`=9'h1A5 and `en`=1 on the same edge → `ps`=9'h1A5, not the shifted value. Next enabled edge → 9'h14B (fb = 1 ^ 0 = 1).
5. `load`=1 with `seed_in`=0:
   - Macro undefined → `ps`=0 and `lockup`=1 held indefinitely.
   - Macro defined → `ps`=9'h001 and `lockup`=0.
6. Assert `reset` asynchronously while at 9'h0F3 with `en`=1 → `ps`=9'h001 before the next clk edge and held while `reset`=1.

Source files
------------

// File: rtl/lfsr9.sv
// lfsr9: Fibonacci LFSR with enable, seed load and lock-up flag; define LFSR9_LOCKUP_RECOVER_EN to auto-recover from the all-zero state
module lfsr9 #(
  parameter int WIDTH = 9,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] ps,
  output logic             lockup
);
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      TAP_ALL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS    = TAP_ALL[WIDTH-1:0];
  localparam logic [31:0]      SEED_32 = SEED;
  localparam logic [WIDTH-1:0] SEED_W  = SEED_32[WIDTH-1:0];

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr9: WIDTH must be in 3..16");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("lfsr9: SEED must be non-zero in the low WIDTH bits");
  end

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] nxt;

  assign shifted = {ps[WIDTH-2:0], ^(ps & TAPS)};
  assign lockup  = (ps == '0);

  // next-state selection: load beats enable, otherwise hold
  always_comb begin
`ifdef LFSR9_LOCKUP_RECOVER_EN
    nxt = load ? ((seed_in == '0) ? SEED_W : seed_in) : en ? ((ps == '0) ? SEED_W : shifted) : ps;
`else
    nxt = load ? seed_in : en ? shifted : ps;
`endif
  end

  // state register, asynchronously forced to SEED
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ps <= SEED_W;
    else       ps <= nxt;
  end
endmodule

// File: tb/tb_lfsr9.sv
// tb_lfsr9: randomized self-checking bench for lfsr9 against an arithmetic reference model
module tb_lfsr9;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [8:0] seed_in = '0;
  logic [8:0] ps;
  logic       lockup;
  int checks = 0;
  int failures = 0;
  int m = 1;

`ifdef LFSR9_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  lfsr9 dut (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .seed_in(seed_in), .ps(ps), .lockup(lockup)
  );

  always #5 clk = ~clk;

  function automatic int model_next(input int p, input bit e, input bit ld, input int sd);
    int fb;
    if (ld) return (sd == 0 && RECOVER) ? 1 : sd;
    if (!e) return p;
    if (p == 0) return RECOVER ? 1 : 0;
    fb = ((p / 256) % 2) ^ ((p / 16) % 2);
    return ((p * 2) % 512) + fb;
  endfunction

  task automatic step(input bit e, input bit ld, input int sd);
    en = e;
    load = ld;
    seed_in = sd[8:0];
    m = model_next(m, e, ld, sd);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name);
    checks++;
    if (ps !== m[8:0] || lockup !== (m == 0)) begin
      failures++;
      $display("FAIL %s: ps=%h lockup=%b expected ps=%h lockup=%b", name, ps, lockup, m[8:0], m == 0);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    m = 1;
    checks++;
    if (ps !== 9'h001 || lockup !== 1'b0) begin
      failures++;
      $display("FAIL reset_assert: ps=%h lockup=%b expected ps=001 lockup=0", ps, lockup);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ps !== 9'h001) begin
      failures++;
      $display("FAIL reset_hold: ps=%h expected 001", ps);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    bit seen [512];
    logic [8:0] first [5];
    first = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
    foreach (seen[i]) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int i = 1; i <= 511; i++) begin
      step(1'b1, 1'b0, 0);
      cmp("seq_model");
      if (i <= 5) begin
        checks++;
        if (ps !== first[i-1]) begin
          failures++;
          $display("FAIL seq_first: step %0d ps=%h expected %h", i, ps, first[i-1]);
        end
      end
      if (i < 511) begin
        checks++;
        if (ps === 9'h000 || seen[ps]) begin
          failures++;
          $display("FAIL seq_unique: step %0d ps=%h zero or repeated", i, ps);
        end
        seen[ps] = 1'b1;
      end else begin
        checks++;
        if (ps !== 9'h001) begin
          failures++;
          $display("FAIL seq_period: ps=%h expected 001 after 511 steps", ps);
        end
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
    checks++;
    if (ps !== 9'h021) begin
      failures++;
      $display("FAIL hold_start: ps=%h expected 021", ps);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 0);
      checks++;
      if (ps !== 9'h021) begin
        failures++;
        $display("FAIL hold: cycle %0d ps=%h expected 021", i, ps);
      end
    end
    step(1'b1, 1'b0, 0);
    checks++;
    if (ps !== 9'h042) begin
      failures++;
      $display("FAIL hold_resume: ps=%h expected 042", ps);
    end
  endtask

  task automatic test_load();
    step(1'b1, 1'b1, 'h1A5);
    checks++;
    if (ps !== 9'h1A5) begin
      failures++;
      $display("FAIL load_priority: ps=%h expected 1a5", ps);
    end
    step(1'b1, 1'b0, 0);
    checks++;
    if (ps !== 9'h14B) begin
      failures++;
      $display("FAIL load_next: ps=%h expected 14b", ps);
    end
    step(1'b0, 1'b1, 'h0F3);
    checks++;
    if (ps !== 9'h0F3) begin
      failures++;
      $display("FAIL load_no_en: ps=%h expected 0f3", ps);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 511)));
      cmp("random");
    end
  endtask

  task automatic test_zero_load();
    step(1'b1, 1'b1, 0);
    checks++;
    if (RECOVER ? (ps !== 9'h001 || lockup !== 1'b0) : (ps !== 9'h000 || lockup !== 1'b1)) begin
      failures++;
      $display("FAIL zero_load: ps=%h lockup=%b recover=%0d", ps, lockup, RECOVER);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 0);
      cmp("zero_stay");
    end
    step(1'b1, 1'b1, 'h0F3);
    cmp("zero_exit");
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 'h0F3);
    en = 1'b1;
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    m = 1;
    checks++;
    if (ps !== 9'h001 || lockup !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: ps=%h lockup=%b expected ps=001 lockup=0", ps, lockup);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ps !== 9'h001) begin
        failures++;
        $display("FAIL async_reset_hold: ps=%h expected 001", ps);
      end
    end
    reset = 1'b0;
    step(1'b1, 1'b0, 0);
    cmp("post_reset");
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_hold();
    test_load();
    test_random();
    test_zero_load();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
